// File: rtl/alu_src_seq.sv
// ALU source-select sequencer: IDLE -> EXEC (EXEC_CYCLES) -> WB -> IDLE, opclass 11 halts until reset.
// Optional WB stall counter output enabled by defining ALU_SRC_SEQ_STALL_CNT_EN.
module alu_src_seq #(
  parameter int unsigned EXEC_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [8:0] instr,
  output logic       in_ready,
  input  logic       wb_ready,
  output logic [1:0] alu_src,
  output logic [3:0] to_ext,
  output logic [3:0] to_inc,
  output logic       reg_we,
  output logic       done,
  output logic       halted
`ifdef ALU_SRC_SEQ_STALL_CNT_EN
  ,
  output logic [7:0] stall_cnt
`endif
);

  localparam int unsigned CNT_W   = 4;
  localparam int unsigned OPND_W  = 4;
  localparam int unsigned OPC_W   = 2;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(EXEC_CYCLES - 1);

  if (EXEC_CYCLES < 1 || EXEC_CYCLES > 15) begin : g_bad_exec_cycles
    $error("alu_src_seq: EXEC_CYCLES must be in 1..15");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_WB   = 2'd2,
    S_HALT = 2'd3
  } state_t;

  state_t              state;
  state_t              next_state;
  logic [CNT_W-1:0]    cnt;
  logic [CNT_W-1:0]    cnt_d;
  logic [OPC_W-1:0]    opc_q;
  logic [OPC_W-1:0]    opc_d;
  logic [OPND_W-1:0]   opnd_q;
  logic [OPND_W-1:0]   opnd_d;
  logic                hs;
  logic                in_ready_d;
  logic [1:0]          alu_src_d;
  logic [OPND_W-1:0]   to_ext_d;
  logic [OPND_W-1:0]   to_inc_d;
  logic                reg_we_d;
  logic                done_d;
  logic                halted_d;
  logic                unused_instr;

  // Bits [6:4] carry no meaning for this sequencer.
  assign unused_instr = ^instr[6:4];

  assign hs = (state == S_IDLE) && in_valid;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (in_valid) begin
          next_state = (instr[8:7] == 2'b11) ? S_HALT : S_EXEC;
        end
      end
      S_EXEC: begin
        if (cnt == '0) begin
          next_state = S_WB;
        end
      end
      S_WB: begin
        if (wb_ready) begin
          next_state = S_IDLE;
        end
      end
      S_HALT:  next_state = S_HALT;
      default: next_state = S_IDLE;
    endcase
  end

  // Output/datapath next values; decode follows the instruction being accepted this cycle
  always_comb begin
    in_ready_d = 1'b0;
    alu_src_d  = 2'b00;
    to_ext_d   = '0;
    to_inc_d   = '0;
    reg_we_d   = 1'b0;
    done_d     = 1'b0;
    halted_d   = 1'b0;
    opc_d      = opc_q;
    opnd_d     = opnd_q;
    cnt_d      = cnt;

    if (hs) begin
      opc_d  = instr[8:7];
      opnd_d = instr[3:0];
      cnt_d  = CNT_LOAD;
    end else if (state == S_EXEC && cnt != '0) begin
      cnt_d = cnt - CNT_W'(1);
    end

    in_ready_d = (next_state == S_IDLE);
    reg_we_d   = (next_state == S_WB);
    halted_d   = (next_state == S_HALT);
    done_d     = (state == S_WB) && wb_ready;

    if (next_state == S_EXEC || next_state == S_WB) begin
      case (opc_d)
        2'b00: begin
          alu_src_d = 2'b00;
          to_ext_d  = opnd_d;
        end
        2'b01: begin
          alu_src_d = 2'b01;
          to_inc_d  = opnd_d;
        end
        2'b10:   alu_src_d = 2'b10;
        default: alu_src_d = 2'b00;
      endcase
    end
  end

  // Output and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready <= 1'b1;
      alu_src  <= 2'b00;
      to_ext   <= '0;
      to_inc   <= '0;
      reg_we   <= 1'b0;
      done     <= 1'b0;
      halted   <= 1'b0;
      opc_q    <= '0;
      opnd_q   <= '0;
      cnt      <= '0;
    end else begin
      in_ready <= in_ready_d;
      alu_src  <= alu_src_d;
      to_ext   <= to_ext_d;
      to_inc   <= to_inc_d;
      reg_we   <= reg_we_d;
      done     <= done_d;
      halted   <= halted_d;
      opc_q    <= opc_d;
      opnd_q   <= opnd_d;
      cnt      <= cnt_d;
    end
  end

`ifdef ALU_SRC_SEQ_STALL_CNT_EN
  // Saturating count of write-back cycles refused by the register file
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (state == S_WB && !wb_ready && stall_cnt != 8'hFF) begin
      stall_cnt <= stall_cnt + 8'd1;
    end
  end
`endif

endmodule
